idli_fetch_m: RTL

Instruction fetch stage directly upstream of the nibble-serial decoder. It reads instructions from an external quad-SPI (SQI) memory, buffers the returned nibbles in a small FIFO, and delivers each 16-bit instruction to the decoder as four back-to-back nibbles on o_dcd_enc/o_dcd_enc_vld. The decoder only samples valid in its idle state, so a started instruction is never interrupted. Control flow changes arrive as redirects carrying a new memory address.

---
 rtl/idli_fetch_m.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/idli_fetch_m.sv
// idli_fetch_m: instruction fetch stage feeding the nibble-serial decoder.
// Reads a continuous nibble stream from a quad-SPI memory (command, address,
// dummy, then data), buffers it in a small FIFO and hands the decoder one
// 16-bit instruction as four back-to-back nibbles.
//
// Ports:
//   i_dcd_gck, i_dcd_rst_n        clock, async active-low reset
//   i_fch_redirect(_addr)         single-cycle restart request + new address
//   i_fch_stall                   holds off the start of the next instruction
//   o_dcd_enc, o_dcd_enc_vld      nibble to the decoder (FIFO head) + valid
//   o_mem_cs_n, o_mem_sck_en      memory chip select / clock enable
//   o_mem_sio_out, o_mem_sio_oe   command/address nibble + drive enable
//   i_mem_sio_in                  read data nibble from memory
module idli_fetch_m #(
  parameter int          ADDR_W = 16,
  parameter int          DUMMY  = 2,
  parameter int          DEPTH  = 8,
  parameter logic [7:0]  CMD    = 8'h03
) (
  input  logic              i_dcd_gck,
  input  logic              i_dcd_rst_n,
  input  logic              i_fch_redirect,
  input  logic [ADDR_W-1:0] i_fch_redirect_addr,
  input  logic              i_fch_stall,
  output logic [3:0]        o_dcd_enc,
  output logic              o_dcd_enc_vld,
  output logic              o_mem_cs_n,
  output logic              o_mem_sck_en,
  output logic [3:0]        o_mem_sio_out,
  output logic              o_mem_sio_oe,
  input  logic [3:0]        i_mem_sio_in
);

  localparam int AN   = ADDR_W / 4;
  localparam int NMAX = (AN > DUMMY) ? ((AN > 2) ? AN : 2) : ((DUMMY > 2) ? DUMMY : 2);
  localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam logic [CW-1:0] C_ALAST = CW'(AN - 1);
  localparam logic [CW-1:0] C_DLAST = CW'(DUMMY - 1);
  localparam logic [PW:0]   C_FULL  = (PW+1)'(DEPTH);
  localparam logic [PW:0]   C_INSN  = (PW+1)'(4);

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_CMD, S_ADDR, S_DUMMY, S_DATA} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_ncnt;
  logic [ADDR_W-1:0] r_addr;      // shifted left one nibble per ADDR cycle
  logic [3:0]        r_fifo [DEPTH];
  logic [PW-1:0]     r_head, r_tail;
  logic [PW:0]       r_cnt;
  logic              r_burst;
  logic [1:0]        r_bcnt;
  logic              r_pend;
  logic [ADDR_W-1:0] r_pend_addr;

  logic              w_last, w_pop, w_push, w_apply, w_start, w_sck_en;
  logic [ADDR_W-1:0] w_apply_addr;
  logic [PW:0]       w_cnt_nxt;

  // A redirect never cuts an instruction short: inside a burst it waits
  // until the edge that ends the final nibble.
  assign w_last       = r_burst & (r_bcnt == 2'd3);
  assign w_pop        = r_burst;
  assign w_apply      = (i_fch_redirect & (~r_burst | w_last)) | (r_pend & w_last);
  assign w_apply_addr = i_fch_redirect ? i_fch_redirect_addr : r_pend_addr;

  // In DATA the memory clock is gated rather than dropping cs_n, so the
  // stream simply pauses while the FIFO is full and nothing is popping.
  always_comb begin
    w_sck_en = 1'b0;
    case (r_state)
      S_CMD, S_ADDR, S_DUMMY: w_sck_en = 1'b1;
      S_DATA:                 w_sck_en = (r_cnt < C_FULL) | w_pop;
      default:                w_sck_en = 1'b0;
    endcase
  end

  // A nibble arriving on the edge that flushes the FIFO belongs to the old
  // stream and is dropped.
  assign w_push = (r_state == S_DATA) & w_sck_en & ~w_apply;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_apply)
      w_cnt_nxt = '0;
    else if (w_push & ~w_pop)
      w_cnt_nxt = r_cnt + 1'b1;
    else if (~w_push & w_pop)
      w_cnt_nxt = r_cnt - 1'b1;
  end

  // Burst start is decided on the edge from the next-cycle count so that
  // valid comes straight out of a flop in the first delivery cycle.
  assign w_start = (~r_burst | w_last) & ~w_apply & ~r_pend & ~i_fch_stall &
                   (w_cnt_nxt >= C_INSN);

  // Memory sequencing FSM
  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      r_state <= S_IDLE;
      r_ncnt  <= '0;
      r_addr  <= '0;
    end else if (w_apply) begin
      r_state <= (r_state == S_IDLE) ? S_CMD : S_GAP;
      r_ncnt  <= '0;
      r_addr  <= w_apply_addr;
    end else begin
      case (r_state)
        S_GAP: begin
          r_state <= S_CMD;
          r_ncnt  <= '0;
        end
        S_CMD: begin
          r_ncnt <= r_ncnt + 1'b1;
          if (r_ncnt == CW'(1)) begin
            r_state <= S_ADDR;
            r_ncnt  <= '0;
          end
        end
        S_ADDR: begin
          r_addr <= r_addr << 4;
          r_ncnt <= r_ncnt + 1'b1;
          if (r_ncnt == C_ALAST) begin
            r_state <= S_DUMMY;
            r_ncnt  <= '0;
          end
        end
        S_DUMMY: begin
          r_ncnt <= r_ncnt + 1'b1;
          if (r_ncnt == C_DLAST) begin
            r_state <= S_DATA;
            r_ncnt  <= '0;
          end
        end
        default: ;  // IDLE waits for a redirect, DATA streams until one
      endcase
    end
  end

  // FIFO control, burst delivery and pending redirect
  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_cnt       <= '0;
      r_burst     <= 1'b0;
      r_bcnt      <= '0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_apply) begin
        r_head <= '0;
        r_tail <= '0;
        r_pend <= 1'b0;
      end else begin
        if (w_push) r_tail <= r_tail + 1'b1;
        if (w_pop)  r_head <= r_head + 1'b1;
        if (i_fch_redirect & r_burst & ~w_last) begin
          r_pend      <= 1'b1;
          r_pend_addr <= i_fch_redirect_addr;
        end
      end
      if (w_start) begin
        r_burst <= 1'b1;
        r_bcnt  <= '0;
      end else if (r_burst) begin
        r_bcnt <= r_bcnt + 1'b1;
        if (w_last) r_burst <= 1'b0;
      end
    end
  end

  // Storage needs no reset: only entries between head and tail are read.
  always_ff @(posedge i_dcd_gck) begin
    if (w_push) r_fifo[r_tail] <= i_mem_sio_in;
  end

  always_comb begin
    o_mem_sio_out = 4'h0;
    case (r_state)
      S_CMD:   o_mem_sio_out = (r_ncnt == '0) ? CMD[7:4] : CMD[3:0];
      S_ADDR:  o_mem_sio_out = r_addr[ADDR_W-1 -: 4];
      default: o_mem_sio_out = 4'h0;
    endcase
  end

  assign o_mem_cs_n    = (r_state == S_IDLE) | (r_state == S_GAP);
  assign o_mem_sio_oe  = (r_state == S_CMD) | (r_state == S_ADDR);
  assign o_mem_sck_en  = w_sck_en;
  assign o_dcd_enc_vld = r_burst;
  assign o_dcd_enc     = r_burst ? r_fifo[r_head] : 4'h0;

endmodule
